// File: rtl/rf68000_biu_pkg.sv
// rf68000_biu_pkg: FSM states, response status codes and the latched request record.
package rf68000_biu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} biu_state_e;
  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BUSERR  = 2'b01,
    ST_PGFAULT = 2'b10,
    ST_TIMEOUT = 2'b11
  } biu_status_e;
  typedef struct packed {
    logic        we;
    logic [2:0]  fc;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ios;
  } biu_req_t;
endpackage

// File: rtl/edge_det.sv
// edge_det: rising-edge detector; pe is high for the cycle in which i first reads 1.
module edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i,
  output logic pe
);
  logic q;
  always_ff @(posedge clk_i) q <= rst_i ? 1'b0 : i;
  assign pe = i & ~q;
endmodule

// File: rtl/rf68000_biu.sv
// rf68000_biu: single-request bus initiator turning MMU stalls into fault/timeout status.
// Define RF68000_BIU_RETRY_EN to retry err_i-terminated cycles up to MAX_RETRY times.
module rf68000_biu #(
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_fc_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic        req_ios_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] resp_dat_o,
  output logic [1:0]  resp_st_o,
  output logic        resp_vpa_o,
  output logic [2:0]  fc_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic        ios_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        vpa_i,
  input  logic [31:0] dat_i,
  input  logic        page_fault_i
);
  import rf68000_biu_pkg::*;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  biu_state_e state, state_d;
  biu_status_e st;
  biu_req_t rq;
  logic [TW-1:0] tcnt;
  logic pf_pe, tmo, term, retry, again;
  edge_det u_pf (.clk_i(clk_i), .rst_i(rst_i), .i(page_fault_i), .pe(pf_pe));
`ifdef RF68000_BIU_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] rcnt;
  assign retry = err_i && (rcnt < RW'(MAX_RETRY));
  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) begin
      rcnt  <= '0;
      again <= 1'b0;
    end else if (state == WAIT && retry) begin
      rcnt  <= rcnt + 1'b1;
      again <= 1'b1;
    end else if (state == ISSUE) again <= 1'b0;
  end
`else
  assign again = 1'b0;
  assign retry = 1'b0 && MAX_RETRY > 0;
`endif
  assign tmo  = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  assign term = err_i || pf_pe || vpa_i || ack_i || tmo;
  assign st   = err_i ? ST_BUSERR : pf_pe ? ST_PGFAULT : (vpa_i || ack_i) ? ST_OK : ST_TIMEOUT;
  always_comb begin
    state_d = state;
    state_d = (state == IDLE)  ? (req_i ? ISSUE : IDLE) :
              (state == ISSUE) ? WAIT :
              (state == WAIT)  ? (term ? RECOVER : WAIT) :
              (ack_i || err_i || vpa_i) ? RECOVER : again ? ISSUE : IDLE;
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {busy_o, done_o, resp_dat_o, resp_st_o, resp_vpa_o} <= '0;
      {fc_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, ios_o} <= '0;
      rq   <= '0;
      tcnt <= '0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE && req_i) begin
        rq <= '{we: req_we_i, fc: req_fc_i, sel: req_sel_i, adr: req_adr_i, dat: req_dat_i, ios: req_ios_i};
        busy_o <= 1'b1;
      end
      if (state == ISSUE) begin
        {cyc_o, stb_o} <= 2'b11;
        {we_o, fc_o, sel_o, adr_o, dat_o, ios_o} <= {rq.we, rq.fc, rq.sel, rq.adr, rq.dat, rq.ios};
        tcnt <= '0;
      end
      if (state == WAIT) tcnt <= tcnt + 1'b1;
      if (state == WAIT && term) begin
        {cyc_o, stb_o, sel_o} <= '0;
        if (!retry) begin
          done_o     <= 1'b1;
          resp_st_o  <= st;
          resp_vpa_o <= (st == ST_OK) && vpa_i;
          // autovector cycles carry no data; only a plain read ack is captured
          if (st == ST_OK && !vpa_i && !rq.we) resp_dat_o <= dat_i;
        end
      end
      if (state == RECOVER && state_d == IDLE) busy_o <= 1'b0;
    end
  end
endmodule
